// File: rtl/pwm_sequencer.sv
// pwm_sequencer: Wishbone-programmable table of {dwell, duty} entries that
// steps a PWM duty value at PWM period boundaries, one-shot or looping.
module pwm_sequencer #(
  parameter int ENTRIES = 8,
  parameter int DUTY_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              pwm_period_end_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              duty_update_o,
  output logic              irq_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_STOPPING} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ack;
  logic [31:0]        r_dat;
  logic               r_loop;
  logic               r_irq_en;
  logic [3:0]         r_len;
  logic               r_done;
  logic               r_irq;
  logic [IDX_W-1:0]   r_idx;
  logic [15:0]        r_cnt;
  logic [DUTY_W-1:0]  r_duty;
  logic               r_upd;
  logic [31:0]        r_table [ENTRIES];

  logic               w_req;
  logic               w_wr;
  logic [4:0]         w_reg;
  logic               w_tbl_hit;
  logic [IDX_W-1:0]   w_tbl_idx;
  logic               w_wr_ctrl;
  logic               w_start;
  logic               w_stop;
  logic               w_done_w1c;
  logic [3:0]         w_len_wr;
  logic [31:0]        w_rdata;
  logic               w_busy;
  logic               w_load;
  logic [IDX_W-1:0]   w_load_idx;
  logic               w_dec;
  logic               w_zero;
  logic               w_set_done;
  logic               w_idx_clr;
  logic [31:0]        w_entry;
  logic [DUTY_W-1:0]  w_duty_nxt;
  logic               w_unused_adr;

  assign w_req      = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr       = w_req & wbs_we_i;
  assign w_reg      = wbs_adr_i[6:2];
  assign w_tbl_hit  = wbs_adr_i[6] && ({1'b0, wbs_adr_i[5:2]} < 5'(ENTRIES));
  assign w_tbl_idx  = wbs_adr_i[2 +: IDX_W];
  assign w_wr_ctrl  = w_wr && (w_reg == 5'd0) && wbs_sel_i[0];
  assign w_start    = w_wr_ctrl & wbs_dat_i[0];
  assign w_stop     = w_wr_ctrl & wbs_dat_i[2];
  assign w_done_w1c = w_wr && (w_reg == 5'd1) && wbs_sel_i[0] && wbs_dat_i[1];
  assign w_len_wr   = (wbs_dat_i[3:0] > 4'(ENTRIES - 1)) ? 4'(ENTRIES - 1) : wbs_dat_i[3:0];
  assign w_busy     = (r_state != S_IDLE);
  assign w_entry    = r_table[w_load_idx];
  assign w_unused_adr = &{1'b0, wbs_adr_i[31:7], wbs_adr_i[1:0]};

  // Read data mux; anything outside the map reads as zero.
  always_comb begin
    w_rdata = 32'd0;
    if (w_tbl_hit) begin
      w_rdata = r_table[w_tbl_idx];
    end else begin
      case (w_reg)
        5'd0: w_rdata = {28'd0, r_irq_en, 1'b0, r_loop, 1'b0};
        5'd1: w_rdata = {24'd0, 4'(r_idx), 2'b00, r_done, w_busy};
        5'd2: w_rdata = {28'd0, r_len};
        default: w_rdata = 32'd0;
      endcase
    end
  end

  // Bus handshake, read data capture and the CTRL/LEN configuration bits.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat    <= 32'd0;
      r_loop   <= 1'b0;
      r_irq_en <= 1'b0;
      r_len    <= 4'd0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : 32'd0;
      if (w_wr_ctrl) begin
        r_loop   <= wbs_dat_i[1];
        r_irq_en <= wbs_dat_i[3];
      end
      if (w_wr && !w_tbl_hit && (w_reg == 5'd2) && wbs_sel_i[0]) begin
        r_len <= w_len_wr;
      end
    end
  end

  // Sequence table: byte-enabled writes, deliberately left out of reset.
  always_ff @(posedge wb_clk_i) begin
    if (w_wr && w_tbl_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) r_table[w_tbl_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and datapath controls; duty only moves on a period end.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = '0;
    w_dec       = 1'b0;
    w_zero      = 1'b0;
    w_set_done  = 1'b0;
    w_idx_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start && !w_stop) begin
          w_state_nxt = S_ARM;
          w_idx_clr   = 1'b1;
        end
      end
      S_ARM: begin
        if (w_stop) begin
          w_state_nxt = S_STOPPING;
        end else if (pwm_period_end_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_stop) begin
          w_state_nxt = S_STOPPING;
        end else if (pwm_period_end_i) begin
          // A counter of 0 (zero dwell) ends the entry just like 1.
          if (r_cnt <= 16'd1) begin
            if (4'(r_idx) >= r_len) begin
              if (r_loop) begin
                w_load = 1'b1;
              end else begin
                w_zero      = 1'b1;
                w_set_done  = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end else begin
              w_load     = 1'b1;
              w_load_idx = r_idx + IDX_W'(1);
            end
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      S_STOPPING: begin
        if (pwm_period_end_i) begin
          w_zero      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next duty value, used both for the register and the update pulse.
  always_comb begin
    w_duty_nxt = r_duty;
    if (w_load) w_duty_nxt = w_entry[DUTY_W-1:0];
    if (w_zero) w_duty_nxt = '0;
  end

  // Index, dwell counter, duty output, DONE and interrupt registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_idx  <= '0;
      r_cnt  <= 16'd0;
      r_duty <= '0;
      r_upd  <= 1'b0;
      r_done <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_idx_clr)  r_idx <= '0;
      else if (w_load) r_idx <= w_load_idx;
      if (w_load)      r_cnt <= w_entry[31:16];
      else if (w_dec)  r_cnt <= r_cnt - 16'd1;
      r_duty <= w_duty_nxt;
      r_upd  <= (w_duty_nxt != r_duty);
      if (w_set_done)      r_done <= 1'b1;
      else if (w_done_w1c) r_done <= 1'b0;
      r_irq <= r_done & r_irq_en;
    end
  end

  assign wbs_ack_o     = r_ack;
  assign wbs_dat_o     = r_dat;
  assign duty_o        = r_duty;
  assign duty_update_o = r_upd;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb_pwm_sequencer: scenario tasks checked against a period-level model of
// the duty sequence built from the table contents the bench has written.
module tb_pwm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, dat = 32'd0;
  logic        ack;
  logic [31:0] dato;
  logic        pend = 1'b0;
  logic [15:0] duty;
  logic        upd;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_duty  [8];
  logic [15:0] m_dwell [8];

  pwm_sequencer #(.ENTRIES(8), .DUTY_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack), .wbs_dat_o(dato),
    .pwm_period_end_i(pend),
    .duty_o(duty), .duty_update_o(upd), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Expected duty after the p-th period pulse of a sequence (p=0: before start).
  function automatic logic [15:0] model_duty(input int p, input int len, input bit lp);
    int total, q, w;
    total = 0;
    for (int k = 0; k <= len; k++) total += (m_dwell[k] == 0) ? 1 : int'(m_dwell[k]);
    if (p <= 0) return 16'h0;
    if (!lp && p > total) return 16'h0;
    q = (p - 1) % total;
    for (int k = 0; k <= len; k++) begin
      w = (m_dwell[k] == 0) ? 1 : int'(m_dwell[k]);
      if (q < w) return m_duty[k];
      q -= w;
    end
    return 16'h0;
  endfunction

  function automatic int model_total(input int len);
    int total;
    total = 0;
    for (int k = 0; k <= len; k++) total += (m_dwell[k] == 0) ? 1 : int'(m_dwell[k]);
    return total;
  endfunction

  // Bus transfer; entered and left at 1 time unit after a clock edge.
  task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd);
    int n;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge clk); #1;
    while (ack !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    if (ack !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL wb_timeout adr=%h no ack after %0d cycles", a, n);
    end
    rd = dato;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] junk;
    wb(1'b1, a, d, 4'hF, junk);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] v);
    wb(1'b0, a, 32'd0, 4'hF, v);
  endtask

  task automatic wr_entry(input int k, input logic [15:0] d, input logic [15:0] dw);
    wr(32'h40 + 32'(4 * k), {dw, d});
    m_duty[k] = d; m_dwell[k] = dw;
  endtask

  // One PWM period: single-cycle end pulse, then idle; returns post-pulse outputs.
  task automatic pulse(output logic [15:0] d, output logic u);
    @(posedge clk); #1 pend = 1'b1;
    @(posedge clk); #1 pend = 1'b0;
    d = duty; u = upd;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (duty !== 16'h0 || upd !== 1'b0 || irq !== 1'b0 || ack !== 1'b0 || dato !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got duty=%h upd=%b irq=%b ack=%b dat=%h want all 0", duty, upd, irq, ack, dato);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rd32(32'h04, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h want 00000000", v); end
    rd32(32'h00, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 00000000", v); end
    rd32(32'h08, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_len got %h want 00000000", v); end
  endtask

  task automatic test_oneshot;
    logic [15:0] d, e;
    logic u;
    logic [31:0] v;
    wr_entry(0, 16'h1000, 16'd2);
    wr_entry(1, 16'h8000, 16'd3);
    wr(32'h08, 32'd1);
    wr(32'h00, 32'h9);
    for (int p = 1; p <= 6; p++) begin
      n_tests++;
      if (duty !== model_duty(p - 1, 1, 1'b0)) begin
        n_fail++; $display("FAIL oneshot_hold p=%0d got %h want %h", p, duty, model_duty(p - 1, 1, 1'b0));
      end
      pulse(d, u);
      e = model_duty(p, 1, 1'b0);
      n_tests++;
      if (d !== e || u !== (e != model_duty(p - 1, 1, 1'b0))) begin
        n_fail++; $display("FAIL oneshot_duty p=%0d got %h/%b want %h/%b", p, d, u, e, e != model_duty(p - 1, 1, 1'b0));
      end
    end
    rd32(32'h04, v);
    n_tests++;
    if (v[1:0] !== 2'b10) begin n_fail++; $display("FAIL oneshot_done status got %b want 10", v[1:0]); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq got %b want 1", irq); end
    wr(32'h04, 32'h2);
    rd32(32'h04, v);
    n_tests++;
    if (v[1:0] !== 2'b00) begin n_fail++; $display("FAIL done_w1c status got %b want 00", v[1:0]); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
  endtask

  task automatic test_loop;
    logic [15:0] d, e;
    logic u;
    logic [31:0] v;
    wr(32'h00, 32'h3);
    for (int p = 1; p <= 12; p++) begin
      pulse(d, u);
      e = model_duty(p, 1, 1'b1);
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL loop_duty p=%0d got %h want %h", p, d, e); end
    end
    rd32(32'h04, v);
    n_tests++;
    if (v[0] !== 1'b1) begin n_fail++; $display("FAIL loop_busy got %b want 1", v[0]); end
    wr(32'h00, 32'h4);
    pulse(d, u);
    rd32(32'h04, v);
    n_tests++;
    if (d !== 16'h0 || v[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL loop_stop got duty=%h st=%b want 0000/00", d, v[1:0]);
    end
  endtask

  task automatic test_stop;
    logic [15:0] d;
    logic u;
    logic [31:0] v;
    wr(32'h00, 32'h1);
    for (int p = 1; p <= 3; p++) pulse(d, u);
    wr(32'h00, 32'h4);
    repeat (3) @(posedge clk);
    #1;
    rd32(32'h04, v);
    n_tests++;
    if (duty !== 16'h8000 || v[0] !== 1'b1) begin
      n_fail++; $display("FAIL stop_hold got duty=%h busy=%b want 8000/1", duty, v[0]);
    end
    pulse(d, u);
    rd32(32'h04, v);
    n_tests++;
    if (d !== 16'h0 || u !== 1'b1 || v[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL stop_end got duty=%h upd=%b st=%b want 0000/1/00", d, u, v[1:0]);
    end
  endtask

  task automatic test_zero_dwell;
    logic [15:0] d, e;
    logic u;
    logic [31:0] v;
    wr(32'h08, 32'hF);
    rd32(32'h08, v);
    n_tests++;
    if (v !== 32'd7) begin n_fail++; $display("FAIL len_saturate got %h want 00000007", v); end
    wr_entry(0, 16'h1111, 16'd0);
    wr_entry(1, 16'h2222, 16'd1);
    wr(32'h08, 32'd1);
    wr(32'h00, 32'h1);
    for (int p = 1; p <= 3; p++) begin
      pulse(d, u);
      e = model_duty(p, 1, 1'b0);
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL zero_dwell p=%0d got %h want %h", p, d, e); end
    end
    wr(32'h04, 32'h2);
  endtask

  task automatic test_bus_sel;
    logic [31:0] v;
    wr(32'h48, 32'hFFFF_FFFF);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h48; dat = 32'h0000_1234; sel = 4'b0001;
    @(posedge clk); #1;
    n_tests++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL ack_latency got %b want 1", ack); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    @(posedge clk); #1;
    n_tests++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_single got %b want 0", ack); end
    rd32(32'h48, v);
    n_tests++;
    if (v !== 32'hFFFF_FF34) begin n_fail++; $display("FAIL byte_sel got %h want ffffff34", v); end
    m_duty[2] = 16'hFF34; m_dwell[2] = 16'hFFFF;
    rd32(32'h1000_0048, v);
    n_tests++;
    if (v !== 32'hFFFF_FF34) begin n_fail++; $display("FAIL upper_adr got %h want ffffff34", v); end
  endtask

  task automatic test_unmapped;
    logic [31:0] v;
    wr(32'h0C, 32'hFFFF_FFFF);
    rd32(32'h0C, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_0c got %h want 00000000", v); end
    wr(32'h60, 32'hFFFF_FFFF);
    rd32(32'h60, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_60 got %h want 00000000", v); end
    wr(32'h00, 32'h5);
    rd32(32'h04, v);
    n_tests++;
    if (v[0] !== 1'b0) begin n_fail++; $display("FAIL start_stop_same busy got %b want 0", v[0]); end
  endtask

  task automatic test_random;
    logic [15:0] d, e;
    logic u;
    logic [31:0] v;
    int len_w, len, np;
    bit lp;
    for (int it = 0; it < 5; it++) begin
      for (int k = 0; k < 8; k++) wr_entry(k, 16'($urandom), 16'($urandom_range(0, 3)));
      len_w = $urandom_range(0, 15);
      len = (len_w > 7) ? 7 : len_w;
      lp = 1'($urandom_range(0, 1));
      wr(32'h08, 32'(len_w));
      rd32(32'h08, v);
      n_tests++;
      if (v !== 32'(len)) begin n_fail++; $display("FAIL rand_len it=%0d got %0d want %0d", it, v, len); end
      wr(32'h00, lp ? 32'h3 : 32'h1);
      np = lp ? 10 : model_total(len) + 1;
      for (int p = 1; p <= np; p++) begin
        pulse(d, u);
        e = model_duty(p, len, lp);
        n_tests++;
        if (d !== e || u !== (e != model_duty(p - 1, len, lp))) begin
          n_fail++; $display("FAIL rand_duty it=%0d p=%0d got %h/%b want %h/%b", it, p, d, u, e, e != model_duty(p - 1, len, lp));
        end
      end
      if (lp) begin
        wr(32'h00, 32'h4);
        pulse(d, u);
      end
      rd32(32'h04, v);
      n_tests++;
      if (v[1:0] !== {~lp, 1'b0} || duty !== 16'h0) begin
        n_fail++; $display("FAIL rand_end it=%0d got st=%b duty=%h want %b/0000", it, v[1:0], duty, {~lp, 1'b0});
      end
      wr(32'h04, 32'h2);
    end
  endtask

  task automatic test_reset_midrun;
    logic [15:0] d;
    logic u;
    logic [31:0] v;
    wr_entry(0, 16'hABCD, 16'd2);
    wr_entry(1, 16'h5555, 16'd2);
    wr(32'h08, 32'd1);
    wr(32'h00, 32'h3);
    for (int p = 1; p <= 3; p++) pulse(d, u);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (duty !== 16'h0 || irq !== 1'b0 || ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_midrun got duty=%h irq=%b ack=%b want 0000/0/0", duty, irq, ack);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rd32(32'h04, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_midrun_status got %h want 00000000", v); end
    for (int k = 0; k < 3; k++) begin
      rd32(32'h40 + 32'(4 * k), v);
      n_tests++;
      if (v !== {m_dwell[k], m_duty[k]}) begin
        n_fail++; $display("FAIL table_keep k=%0d got %h want %h", k, v, {m_dwell[k], m_duty[k]});
      end
    end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_loop;
    test_stop;
    test_zero_dwell;
    test_bus_sel;
    test_unmapped;
    test_random;
    test_reset_midrun;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
